// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the instruction-fetch and load/store requesters.
// Data wins arbitration by default; a saturating starvation counter forces a fetch grant.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic        o_if_gnt,
  output logic        o_if_rvalid,
  output logic [31:0] o_if_rdata,
  input  logic        i_d_req,
  input  logic        i_d_we,
  input  logic [31:0] i_d_addr,
  input  logic [31:0] i_d_wdata,
  input  logic [31:0] i_d_mask,
  output logic        o_d_gnt,
  output logic        o_d_rvalid,
  output logic [31:0] o_d_rdata,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [31:0] o_mem_mask,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state_reg, state_next;
  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg, wdata_reg, mask_reg;
  logic        if_rvalid_reg, d_rvalid_reg;
  logic [31:0] if_rdata_reg, d_rdata_reg;
  logic        if_gnt, d_gnt, busy;

  always_comb begin
    state_next      = state_reg;
    starve_cnt_next = starve_cnt_reg;
    if_gnt          = 1'b0;
    d_gnt           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (i_d_req && !(i_if_req && (starve_cnt_reg == LIMIT))) begin
          d_gnt = 1'b1;
        end else if (i_if_req) begin
          if_gnt = 1'b1;
        end
        if (d_gnt) begin
          state_next = BUSY_D;
          if (!i_if_req) begin
            starve_cnt_next = 4'd0;
          end else if (starve_cnt_reg < LIMIT) begin
            starve_cnt_next = starve_cnt_reg + 4'd1;
          end
        end else if (if_gnt) begin
          state_next      = BUSY_I;
          starve_cnt_next = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (i_mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      starve_cnt_reg <= 4'd0;
      we_reg         <= 1'b0;
      addr_reg       <= 32'd0;
      wdata_reg      <= 32'd0;
      mask_reg       <= 32'd0;
      if_rvalid_reg  <= 1'b0;
      d_rvalid_reg   <= 1'b0;
      if_rdata_reg   <= 32'd0;
      d_rdata_reg    <= 32'd0;
    end else begin
      state_reg      <= state_next;
      starve_cnt_reg <= starve_cnt_next;
      if (d_gnt) begin
        we_reg    <= i_d_we;
        addr_reg  <= i_d_addr;
        wdata_reg <= i_d_wdata;
        mask_reg  <= i_d_mask;
      end else if (if_gnt) begin
        we_reg    <= 1'b0;
        addr_reg  <= i_if_addr;
        wdata_reg <= 32'd0;
        mask_reg  <= 32'd0;
      end
      if_rvalid_reg <= (state_reg == BUSY_I) && i_mem_ack;
      d_rvalid_reg  <= (state_reg == BUSY_D) && i_mem_ack;
      if ((state_reg == BUSY_I) && i_mem_ack) begin
        if_rdata_reg <= i_mem_rdata;
      end
      if ((state_reg == BUSY_D) && i_mem_ack) begin
        d_rdata_reg <= we_reg ? 32'd0 : i_mem_rdata;
      end
    end
  end

  // Memory fields read as zero outside a transaction so IDLE never shows stale values.
  assign busy        = (state_reg == BUSY_I) || (state_reg == BUSY_D);
  assign o_mem_req   = busy;
  assign o_mem_we    = busy & we_reg;
  assign o_mem_addr  = busy ? addr_reg  : 32'd0;
  assign o_mem_wdata = busy ? wdata_reg : 32'd0;
  assign o_mem_mask  = busy ? mask_reg  : 32'd0;

  assign o_if_gnt    = if_gnt;
  assign o_d_gnt     = d_gnt;
  assign o_if_rvalid = if_rvalid_reg;
  assign o_if_rdata  = if_rdata_reg;
  assign o_d_rvalid  = d_rvalid_reg;
  assign o_d_rdata   = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: inputs change just after the rising edge,
// outputs are checked on the falling edge of the same cycle.
module tb_mem_port_arbiter;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic        o_if_gnt, o_if_rvalid;
  logic [31:0] o_if_rdata;
  logic        i_d_req, i_d_we;
  logic [31:0] i_d_addr, i_d_wdata, i_d_mask;
  logic        o_d_gnt, o_d_rvalid;
  logic [31:0] o_d_rdata;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata, o_mem_mask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
    .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
    .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_addr(i_d_addr),
    .i_d_wdata(i_d_wdata), .i_d_mask(i_d_mask), .o_d_gnt(o_d_gnt),
    .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"},    32'(o_if_gnt),    32'd0);
    chk({tag, "_d_gnt"},     32'(o_d_gnt),     32'd0);
    chk({tag, "_if_rvalid"}, 32'(o_if_rvalid), 32'd0);
    chk({tag, "_d_rvalid"},  32'(o_d_rvalid),  32'd0);
    chk({tag, "_if_rdata"},  o_if_rdata,       32'd0);
    chk({tag, "_d_rdata"},   o_d_rdata,        32'd0);
    chk({tag, "_mem_req"},   32'(o_mem_req),   32'd0);
    chk({tag, "_mem_we"},    32'(o_mem_we),    32'd0);
    chk({tag, "_mem_addr"},  o_mem_addr,       32'd0);
    chk({tag, "_mem_wdata"}, o_mem_wdata,      32'd0);
    chk({tag, "_mem_mask"},  o_mem_mask,       32'd0);
  endtask

  initial begin
    i_rst = 1'b1; i_if_req = 1'b0; i_if_addr = 32'd0;
    i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = 32'd0; i_d_wdata = 32'd0; i_d_mask = 32'd0;
    i_mem_ack = 1'b0; i_mem_rdata = 32'd0;
    tick(); tick();
    sample(); chk_all_zero("reset");
    tick(); i_rst = 1'b0;

    // Reset mid-transaction: store to 0x200 abandoned
    i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h200; i_d_wdata = 32'h11; i_d_mask = 32'hFF;
    sample(); chk("rmt_d_gnt", 32'(o_d_gnt), 32'd1); chk("rmt_if_gnt", 32'(o_if_gnt), 32'd0);
    $display("txn reset-mid: data store granted");
    tick(); i_d_req = 1'b0;
    sample(); chk("rmt_mem_req", 32'(o_mem_req), 32'd1); chk("rmt_mem_addr", o_mem_addr, 32'h200);
    chk("rmt_mem_we", 32'(o_mem_we), 32'd1);
    tick(); i_rst = 1'b1; i_mem_ack = 1'b1;
    tick(); i_rst = 1'b0; i_mem_ack = 1'b0;
    sample(); chk_all_zero("rmt_after");
    tick(); i_mem_ack = 1'b1; i_mem_rdata = 32'h99;
    tick(); i_mem_ack = 1'b0;
    sample(); chk("rmt_late_d_rvalid", 32'(o_d_rvalid), 32'd0);
    chk("rmt_late_if_rvalid", 32'(o_if_rvalid), 32'd0);
    tick(); i_if_req = 1'b1; i_if_addr = 32'h80;
    sample(); chk("rmt_fetch_gnt", 32'(o_if_gnt), 32'd1);
    tick(); i_if_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h1234;
    sample(); chk("rmt_fetch_addr", o_mem_addr, 32'h80);
    tick(); i_mem_ack = 1'b0;
    sample(); chk("rmt_fetch_rvalid", 32'(o_if_rvalid), 32'd1);
    chk("rmt_fetch_rdata", o_if_rdata, 32'h1234);
    $display("txn reset-mid: fetch after reset rdata=%h", o_if_rdata);

    // Single fetch 0x40
    tick(); i_if_req = 1'b1; i_if_addr = 32'h40;
    sample(); chk("sf_if_gnt", 32'(o_if_gnt), 32'd1); chk("sf_d_gnt", 32'(o_d_gnt), 32'd0);
    chk("sf_c0_mem_req", 32'(o_mem_req), 32'd0);
    tick(); i_if_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'hDEADBEEF;
    sample(); chk("sf_mem_req", 32'(o_mem_req), 32'd1); chk("sf_mem_addr", o_mem_addr, 32'h40);
    chk("sf_mem_we", 32'(o_mem_we), 32'd0); chk("sf_mem_mask", o_mem_mask, 32'd0);
    tick(); i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
    sample(); chk("sf_rvalid", 32'(o_if_rvalid), 32'd1); chk("sf_rdata", o_if_rdata, 32'hDEADBEEF);
    chk("sf_mem_req_drop", 32'(o_mem_req), 32'd0); chk("sf_d_rvalid", 32'(o_d_rvalid), 32'd0);
    $display("txn single-fetch: addr=40 rdata=%h", o_if_rdata);
    tick();
    sample(); chk("sf_rvalid_pulse", 32'(o_if_rvalid), 32'd0); chk("sf_rdata_hold", o_if_rdata, 32'hDEADBEEF);

    // Collision: data load wins, waiting fetch granted as data completes
    tick(); i_if_req = 1'b1; i_if_addr = 32'h44;
    i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h300; i_d_wdata = 32'h0; i_d_mask = 32'h0;
    sample(); chk("col_d_gnt", 32'(o_d_gnt), 32'd1); chk("col_if_gnt", 32'(o_if_gnt), 32'd0);
    tick(); i_d_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h5555AAAA;
    sample(); chk("col_mem_addr", o_mem_addr, 32'h300); chk("col_busy_if_gnt", 32'(o_if_gnt), 32'd0);
    tick(); i_mem_ack = 1'b0;
    sample(); chk("col_d_rvalid", 32'(o_d_rvalid), 32'd1); chk("col_d_rdata", o_d_rdata, 32'h5555AAAA);
    chk("col_if_gnt_after", 32'(o_if_gnt), 32'd1);
    $display("txn collision: load rdata=%h, fetch granted", o_d_rdata);
    tick(); i_if_req = 1'b0; i_mem_ack = 1'b1; i_mem_rdata = 32'h77;
    sample(); chk("col_fetch_addr", o_mem_addr, 32'h44);
    tick(); i_mem_ack = 1'b0;
    sample(); chk("col_if_rdata", o_if_rdata, 32'h77); chk("col_if_rvalid", 32'(o_if_rvalid), 32'd1);

    // Store with ack delayed 3 cycles
    tick(); i_d_req = 1'b1; i_d_we = 1'b1; i_d_addr = 32'h104; i_d_wdata = 32'h0000AB00; i_d_mask = 32'h0000FF00;
    sample(); chk("st_d_gnt", 32'(o_d_gnt), 32'd1);
    tick(); i_d_req = 1'b0; i_d_we = 1'b0; i_d_addr = 32'h0; i_d_wdata = 32'h0; i_d_mask = 32'h0;
    for (int k = 0; k < 4; k++) begin
      i_mem_ack = (k == 3); i_mem_rdata = 32'hCAFE0000;
      sample();
      chk("st_mem_req", 32'(o_mem_req), 32'd1); chk("st_mem_we", 32'(o_mem_we), 32'd1);
      chk("st_mem_addr", o_mem_addr, 32'h104); chk("st_mem_wdata", o_mem_wdata, 32'h0000AB00);
      chk("st_mem_mask", o_mem_mask, 32'h0000FF00); chk("st_early_rvalid", 32'(o_d_rvalid), 32'd0);
      tick();
    end
    i_mem_ack = 1'b0;
    sample(); chk("st_rvalid", 32'(o_d_rvalid), 32'd1); chk("st_rdata", o_d_rdata, 32'd0);
    chk("st_mem_req_drop", 32'(o_mem_req), 32'd0);
    $display("txn store: addr=104 rvalid=%0b rdata=%h", o_d_rvalid, o_d_rdata);

    // Starvation: both held, 4 data grants then a fetch, then data again
    tick(); i_if_req = 1'b1; i_if_addr = 32'h500; i_d_req = 1'b1; i_d_we = 1'b0; i_d_addr = 32'h600;
    for (int g = 0; g < 6; g++) begin
      sample();
      chk("stv_d_gnt", 32'(o_d_gnt), (g == 4) ? 32'd0 : 32'd1);
      chk("stv_if_gnt", 32'(o_if_gnt), (g == 4) ? 32'd1 : 32'd0);
      $display("txn starve: grant %0d d_gnt=%0b if_gnt=%0b", g, o_d_gnt, o_if_gnt);
      tick();
      if (g == 5) begin
        i_if_req = 1'b0; i_d_req = 1'b0;
      end
      i_mem_ack = 1'b1; i_mem_rdata = 32'h0;
      sample();
      chk("stv_busy_gnt", 32'(o_d_gnt | o_if_gnt), 32'd0);
      chk("stv_mem_addr", o_mem_addr, (g == 4) ? 32'h500 : 32'h600);
      tick(); i_mem_ack = 1'b0;
    end

    // Spurious ack in IDLE
    tick(); i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
    sample(); chk("sp_gnt", 32'(o_d_gnt | o_if_gnt), 32'd0); chk("sp_mem_req", 32'(o_mem_req), 32'd0);
    tick();
    sample(); chk("sp_mem_req2", 32'(o_mem_req), 32'd0);
    tick(); i_mem_ack = 1'b0;
    sample(); chk("sp_if_rvalid", 32'(o_if_rvalid), 32'd0); chk("sp_d_rvalid", 32'(o_d_rvalid), 32'd0);
    chk("sp_if_rdata_hold", o_if_rdata, 32'h0);
    tick(); i_d_req = 1'b1; i_d_addr = 32'h700;
    sample(); chk("sp_idle_d_gnt", 32'(o_d_gnt), 32'd1);
    $display("txn spurious-ack: ignored, later data grant=%0b", o_d_gnt);
    tick(); i_d_req = 1'b0; i_mem_ack = 1'b1;
    tick(); i_mem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single shared memory port between the core's instruction-fetch requester and its load/store requester, so the fetch path and the data path can share one physical memory. It accepts one request at a time via a request/grant handshake and latches it. It then drives the memory port until the memory acknowledges, and routes the response back to the requester that owns the transaction. Data accesses win arbitration by default, and a starvation counter guarantees forward progress for instruction fetch.

## Interface
- STARVE_LIMIT, default 4: maximum number of consecutive data grants allowed while a fetch request is waiting (legal range 1..15).

- i_clk  in  1  clock; all state updates on its rising edge
- i_rst  in  1  synchronous, active-high reset
- i_if_req  in  1  fetch request; held with address stable until granted
- i_if_addr  in  32  fetch byte address
- o_if_gnt  out  1  fetch request accepted this cycle
- o_if_rvalid  out  1  one-cycle pulse; o_if_rdata valid
- o_if_rdata  out  32  fetched word
- i_d_req  in  1  data request; held with all fields stable until granted
- i_d_we  in  1  1 = store, 0 = load
- i_d_addr  in  32  data byte address
- i_d_wdata  in  32  store data, already lane-shifted
- i_d_mask  in  32  store bit mask
- o_d_gnt  out  1  data request accepted this cycle
- o_d_rvalid  out  1  one-cycle completion pulse for loads and stores
- o_d_rdata  out  32  load data; 0 on store completion
- o_mem_req  out  1  memory transaction active
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  32  memory address
- o_mem_wdata  out  32  memory write data
- o_mem_mask  out  32  memory write mask; 0 for reads
- i_mem_ack  in  1  memory completes the current transaction this cycle
- i_mem_rdata  in  32  read data, valid when i_mem_ack = 1

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- **Grant rule.** Grants are combinational and occur only in IDLE.
  - Only one requester active: grant that requester.
  - Both active: grant data, unless starve_cnt == STARVE_LIMIT, in which case grant fetch.
  - At most one of o_if_gnt and o_d_gnt is high in any cycle.
- **Grant edge.** Latch addr, we, wdata and mask into the transaction registers (fetch: we = 0, mask = 0, wdata = 0). Move to BUSY_I or BUSY_D.
- **BUSY_x.**
  - o_mem_req = 1 and the o_mem_* fields equal the latched values. They are held constant until ack.
  - On i_mem_ack = 1: register i_mem_rdata into the owner's rdata (0 for a store), pulse the owner's rvalid on the next cycle, and return to IDLE.
- **Starvation counter (starve_cnt, 4 bits, saturating at STARVE_LIMIT).**
  - Data grant with i_if_req = 1: increment.
  - Fetch grant: clear to 0.
  - Data grant with i_if_req = 0: clear to 0.
- **Boundary behaviour.**
  - i_mem_ack while in IDLE is ignored.
  - A requester that drops its request before grant is simply not granted; no error.
  - Rdata registers hold their last value when rvalid is low.
  - Requests arriving in BUSY wait; they are never granted while BUSY.

## Timing
- Reset (i_rst high at an edge) takes effect at that edge and wins over everything:
  - state = IDLE, starve_cnt = 0.
  - All outputs 0: o_*_gnt, o_*_rvalid, o_*_rdata, and all o_mem_* fields.
  - An in-flight transaction is abandoned and no rvalid is produced for it.
- Best-case turnaround: request in cycle N (IDLE) → gnt in N → o_mem_req in N+1 → ack in N+1 → rvalid in N+2 → IDLE in N+2, able to grant again in N+2.
- o_mem_req deasserts in the cycle after ack; back-to-back transactions leave at least one cycle with o_mem_req = 0.
- A rvalid pulse and a new grant may coincide in the same cycle.
- Throughput is at most one transaction per 2 cycles.

## Test plan
- **Reset mid-transaction.** Reset while in BUSY_D with o_mem_req = 1 → next cycle all outputs 0. A later i_mem_ack produces no rvalid. A fresh fetch request is then granted normally.
- **Single fetch.** i_if_req with addr 0x40, ack on the first BUSY cycle with rdata 0xDEADBEEF → o_if_gnt in cycle 0; o_mem_req = 1, o_mem_addr = 0x40, o_mem_we = 0 in cycle 1; o_if_rvalid = 1 with rdata 0xDEADBEEF in cycle 2.
- **Store.** i_d_req with we = 1, addr 0x104, wdata 0x0000AB00, mask 0x0000FF00, ack delayed 3 cycles → o_mem_* stable for all 4 BUSY cycles; o_d_rvalid with rdata 0 exactly one cycle after ack.
- **Collision.** Both requests asserted in the same IDLE cycle with starve_cnt = 0 → o_d_gnt = 1 and o_if_gnt = 0. Fetch is granted in the first IDLE after the data completion if the data request has dropped.
- **Starvation.** Hold i_if_req and keep i_d_req asserted continuously, STARVE_LIMIT = 4 → exactly 4 data grants, then a fetch grant, then starve_cnt returns to 0 and data wins again.
- **Spurious ack.** i_mem_ack pulses in IDLE → no rvalid on either port, state stays IDLE, no grant occurs without a request.
